// File: rtl/cplx_pkg.sv
// Shared constants and types for the complex ALU scheduler.
// Holds the opcode values, the FSM state encoding and the default datapath width.
package cplx_pkg;

    localparam int W_DEFAULT = 16;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CMUL = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M1   = 3'd1,
        M2   = 3'd2,
        M3   = 3'd3,
        FIN  = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/cplx_mul_unit.sv
// Shared W x W multiplier with a registered output P.
// P keeps only the low W bits of the product and has one cycle of latency.
module cplx_mul_unit #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] p
);

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else if (en) begin
            p <= x * y;
        end
    end

endmodule

// File: rtl/cplx_alu_sched.sv
// Two-requester complex add/sub/mul unit that time-shares one registered multiplier (3-product multiply).
// Define CPLX_SEQ_CONJ_EN so that op=11 multiplies by the conjugate; otherwise op=11 behaves as mul.
module cplx_alu_sched
    import cplx_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req0_c,
    input  logic [W-1:0] req0_d,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [W-1:0] req1_c,
    input  logic [W-1:0] req1_d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_id
);

    state_t       state, state_nxt;
    logic         rr_last;
    logic         grant0, grant1, accept, sel;
    logic [1:0]   op_sel;
    logic [W-1:0] a_sel, b_sel, c_sel, d_sel, d_lat;
    logic [W-1:0] a_q, b_q, c_q, d_q;
    logic [W-1:0] acc_re, acc_im;
    logic         mul_en;
    logic [W-1:0] mul_x, mul_y, p;

    // Round-robin: on a tie the requester that did not win last time is granted.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || rr_last);
        grant1     = req1_valid && (!req0_valid || !rr_last);
        req0_ready = (state == IDLE) && grant0;
        req1_ready = (state == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        sel        = grant1;
        op_sel     = sel ? req1_op : req0_op;
        a_sel      = sel ? req1_a  : req0_a;
        b_sel      = sel ? req1_b  : req0_b;
        c_sel      = sel ? req1_c  : req0_c;
        d_sel      = sel ? req1_d  : req0_d;
    end

`ifdef CPLX_SEQ_CONJ_EN
    assign d_lat = (op_sel == OP_CMUL) ? -d_sel : d_sel;
`else
    assign d_lat = d_sel;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (op_sel == OP_ADD || op_sel == OP_SUB) ? DONE : M1;
                end
            end
            M1:      state_nxt = M2;
            M2:      state_nxt = M3;
            M3:      state_nxt = FIN;
            FIN:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pre-adders feed the shared multiplier one partial product per cycle.
    always_comb begin
        out_valid = (state == DONE);
        mul_en    = 1'b0;
        mul_x     = '0;
        mul_y     = '0;
        case (state)
            M1: begin mul_en = 1'b1; mul_x = c_q; mul_y = a_q + b_q; end
            M2: begin mul_en = 1'b1; mul_x = a_q; mul_y = d_q - c_q; end
            M3: begin mul_en = 1'b1; mul_x = b_q; mul_y = c_q + d_q; end
            default: ;
        endcase
    end

    cplx_mul_unit #(.W(W)) u_mul (
        .clk (clk),
        .rst (rst),
        .en  (mul_en),
        .x   (mul_x),
        .y   (mul_y),
        .p   (p)
    );

    // Add/sub resolve in the accept cycle; mul results land in FIN from the accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            acc_re  <= '0;
            acc_im  <= '0;
            out_re  <= '0;
            out_im  <= '0;
            out_id  <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a_sel;
                b_q     <= b_sel;
                c_q     <= c_sel;
                d_q     <= d_lat;
                rr_last <= sel;
                out_id  <= sel;
                if (op_sel == OP_ADD) begin
                    out_re <= a_sel + c_sel;
                    out_im <= b_sel + d_sel;
                end else if (op_sel == OP_SUB) begin
                    out_re <= a_sel - c_sel;
                    out_im <= b_sel - d_sel;
                end
            end
            case (state)
                M2: begin
                    acc_re <= p;
                    acc_im <= p;
                end
                M3:  acc_im <= acc_im + p;
                FIN: begin
                    out_re <= acc_re - p;
                    out_im <= acc_im;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cplx_alu_sched.sv
// Self-checking bench for cplx_alu_sched: vector table plus scoreboard, then arbitration,
// backpressure and mid-operation reset sequences.
module tb_cplx_alu_sched;
    import cplx_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req0_c, req0_d;
    logic [W-1:0] req1_a, req1_b, req1_c, req1_d;
    logic         out_valid, out_ready, out_id;
    logic [W-1:0] out_re, out_im;

    typedef struct {
        bit         req;
        logic [1:0] op;
        logic [15:0] a, b, c, d, re, im;
        int         lat;
    } vec_t;

    typedef struct {
        logic [15:0] re, im;
        bit          id;
        int          lat;
    } exp_t;

    typedef struct {
        bit id;
        int cyc;
    } acc_t;

    vec_t vecs[12];
    exp_t sb[$];
    acc_t accept_log[$];
    int   n_total = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   seen_valid = 1'b0;

    cplx_alu_sched #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_c     (req0_c),
        .req0_d     (req0_d),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_c     (req1_c),
        .req1_d     (req1_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_id     (out_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic timeoutFail(input string name);
        n_total++;
        $display("[TB] FAIL %s: wait bound expired, got timeout, expected event", name);
    endtask

    // Reference model uses the plain 4-product formula, truncated to 16 bits.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [15:0] a, b, c, d);
        logic [15:0] dd, re, im;
        dd = d;
`ifdef CPLX_SEQ_CONJ_EN
        if (op == 2'b11) dd = -d;
`endif
        case (op)
            2'b00:   begin re = a + c; im = b + d; end
            2'b10:   begin re = a - c; im = b - d; end
            default: begin re = a * c - b * dd; im = a * dd + b * c; end
        endcase
        return {re, im};
    endfunction

    // Scoreboard side: log accepts, check latency on first valid, pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            seen_valid = 1'b0;
        end else begin
            if (req0_valid && req0_ready) begin
                accept_log.push_back('{1'b0, cyc});
                last_acc = cyc;
            end
            if (req1_valid && req1_ready) begin
                accept_log.push_back('{1'b1, cyc});
                last_acc = cyc;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!seen_valid) begin
                        checkOutput("latency", 32'(cyc - last_acc), 32'(sb[0].lat));
                        seen_valid = 1'b1;
                    end
                    if (out_ready) begin
                        exp_t e;
                        e = sb.pop_front();
                        checkOutput("out_re", 32'(out_re), 32'(e.re));
                        checkOutput("out_im", 32'(out_im), 32'(e.im));
                        checkOutput("out_id", 32'(out_id), 32'(e.id));
                        seen_valid = 1'b0;
                    end
                end
            end
        end
    end

    task automatic setReq(input bit r, input bit v, input logic [1:0] op,
                          input logic [15:0] a, b, c, d);
        if (!r) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_c = c; req0_d = d;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_c = c; req1_d = d;
        end
    endtask

    task automatic waitAccept(input bit r);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (r ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeoutFail("accept_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeoutFail("drain_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        sb.push_back('{v.re, v.im, v.req, v.lat});
        setReq(v.req, 1'b1, v.op, v.a, v.b, v.c, v.d);
        waitAccept(v.req);
        setReq(v.req, 1'b0, v.op, v.a, v.b, v.c, v.d);
        waitDrain();
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_re", 32'(out_re), 32'd0);
        checkOutput("reset_out_im", 32'(out_im), 32'd0);
        checkOutput("reset_out_id", 32'(out_id), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int h;
        rst = 1'b1;
        out_ready = 1'b1;
        setReq(1'b0, 1'b0, OP_ADD, 16'd0, 16'd0, 16'd0, 16'd0);
        setReq(1'b1, 1'b0, OP_ADD, 16'd0, 16'd0, 16'd0, 16'd0);

        vecs[0] = '{1'b0, OP_MUL, 16'd3, 16'd4, 16'd8, 16'd9, 16'hFFF4, 16'd59, 5};
        vecs[1] = '{1'b1, OP_ADD, 16'd3, 16'd4, 16'd8, 16'd9, 16'd11, 16'd13, 1};
        vecs[2] = '{1'b1, OP_SUB, 16'd3, 16'd4, 16'd8, 16'd9, 16'hFFFB, 16'hFFFB, 1};
`ifdef CPLX_SEQ_CONJ_EN
        vecs[3] = '{1'b0, OP_CMUL, 16'd3, 16'd4, 16'd8, 16'd9, 16'd60, 16'd5, 5};
`else
        vecs[3] = '{1'b0, OP_CMUL, 16'd3, 16'd4, 16'd8, 16'd9, 16'hFFF4, 16'd59, 5};
`endif
        vecs[4] = '{1'b1, OP_MUL, 16'd2, 16'd4, 16'hFFFA, 16'hFFFD, 16'd0, 16'hFFE2, 5};
        vecs[5] = '{1'b0, OP_ADD, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001, 16'h0000, 16'h8000, 1};
        vecs[6] = '{1'b1, OP_MUL, 16'd0, 16'd1, 16'd0, 16'd1, 16'hFFFF, 16'd0, 5};
        vecs[7] = '{1'b0, OP_MUL, 16'h0100, 16'd0, 16'h0100, 16'd0, 16'd0, 16'd0, 5};
        for (int i = 8; i < 12; i++) begin
            logic [31:0] m;
            vecs[i].req = i[0];
            vecs[i].op  = 2'($urandom_range(0, 3));
            vecs[i].a   = 16'($urandom);
            vecs[i].b   = 16'($urandom);
            vecs[i].c   = 16'($urandom);
            vecs[i].d   = 16'($urandom);
            m = model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
            vecs[i].re  = m[31:16];
            vecs[i].im  = m[15:0];
            vecs[i].lat = (vecs[i].op == OP_ADD || vecs[i].op == OP_SUB) ? 1 : 5;
        end

        doReset();
        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        // Reset after results so the cleared outputs are meaningful.
        doReset();

        // Both requesters hammer the unit: grants must go 0,1,0 with 6-cycle spacing.
        base = accept_log.size();
        for (int k = 0; k < 3; k++) sb.push_back('{16'd0, 16'hFFE2, k[0], 5});
        setReq(1'b0, 1'b1, OP_MUL, 16'd2, 16'd4, 16'hFFFA, 16'hFFFD);
        setReq(1'b1, 1'b1, OP_MUL, 16'd2, 16'd4, 16'hFFFA, 16'hFFFD);
        for (int i = 0; i < 80 && accept_log.size() < base + 3; i++) @(negedge clk);
        @(posedge clk);
        #1;
        setReq(1'b0, 1'b0, OP_MUL, 16'd0, 16'd0, 16'd0, 16'd0);
        setReq(1'b1, 1'b0, OP_MUL, 16'd0, 16'd0, 16'd0, 16'd0);
        if (accept_log.size() < base + 3) begin
            timeoutFail("arb_three_grants");
        end else begin
            checkOutput("arb_grant0", 32'(accept_log[base].id), 32'd0);
            checkOutput("arb_grant1", 32'(accept_log[base+1].id), 32'd1);
            checkOutput("arb_grant2", 32'(accept_log[base+2].id), 32'd0);
            checkOutput("arb_spacing1", 32'(accept_log[base+1].cyc - accept_log[base].cyc), 32'd6);
            checkOutput("arb_spacing2", 32'(accept_log[base+2].cyc - accept_log[base+1].cyc), 32'd6);
        end
        waitDrain();

        // Backpressure: result must hold and no new accept while the consumer stalls.
        out_ready = 1'b0;
        sb.push_back('{16'd4, 16'd6, 1'b0, 1});
        setReq(1'b0, 1'b1, OP_ADD, 16'd1, 16'd2, 16'd3, 16'd4);
        waitAccept(1'b0);
        setReq(1'b0, 1'b0, OP_ADD, 16'd0, 16'd0, 16'd0, 16'd0);
        sb.push_back('{16'd12, 16'd14, 1'b1, 1});
        setReq(1'b1, 1'b1, OP_ADD, 16'd5, 16'd6, 16'd7, 16'd8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_re", 32'(out_re), 32'd4);
            checkOutput("bp_hold_im", 32'(out_im), 32'd6);
            checkOutput("bp_valid_ready", {29'd0, out_valid, req0_ready, req1_ready}, 32'b100);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        h = cyc;
        @(negedge clk);
        checkOutput("bp_accept_after_release", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        setReq(1'b1, 1'b0, OP_ADD, 16'd0, 16'd0, 16'd0, 16'd0);
        waitDrain();
        checkOutput("bp_accept_cycle", 32'(accept_log[$].cyc - h), 32'd1);

        // Reset during M2 discards the multiply and restores requester-0 tie priority.
        sb.push_back('{16'hFFF4, 16'd59, 1'b0, 5});
        setReq(1'b0, 1'b1, OP_MUL, 16'd3, 16'd4, 16'd8, 16'd9);
        waitAccept(1'b0);
        setReq(1'b0, 1'b0, OP_MUL, 16'd0, 16'd0, 16'd0, 16'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        sb.push_back('{16'd2, 16'd2, 1'b0, 1});
        sb.push_back('{16'd4, 16'd4, 1'b1, 1});
        setReq(1'b0, 1'b1, OP_ADD, 16'd1, 16'd1, 16'd1, 16'd1);
        setReq(1'b1, 1'b1, OP_ADD, 16'd2, 16'd2, 16'd2, 16'd2);
        @(negedge clk);
        checkOutput("tie_after_reset", {30'd0, req0_ready, req1_ready}, 32'b10);
        @(posedge clk);
        #1;
        setReq(1'b0, 1'b0, OP_ADD, 16'd0, 16'd0, 16'd0, 16'd0);
        waitAccept(1'b1);
        setReq(1'b1, 1'b0, OP_ADD, 16'd0, 16'd0, 16'd0, 16'd0);
        waitDrain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cplx_alu_sched.md
Name: cplx_alu_sched

Overview:
- Two-requester scheduler that time-shares one registered W×W multiplier to compute complex add, sub and multiply.
- Complex multiply uses the 3-product scheme, sequenced over three multiplier cycles:
  - s1 = c·(a+b), s2 = a·(d−c), s3 = b·(c+d)
  - re = s1−s3, im = s1+s2
- Sits between the complex-operand producers and downstream consumers.
- Replaces four parallel multipliers with one shared multiplier plus sequencing.

Parameters:
- W, 16, operand/result width. All arithmetic is two's complement, truncated to the low W bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when high with valid
- req0_op  in  2  00 add, 01 mul, 10 sub, 11 conj-mul
- req0_a, req0_b, req0_c, req0_d  in  W each  operands (a+bi), (c+di)
- req1_valid, req1_ready, req1_op, req1_a..req1_d  same as requester 0, for requester 1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_re, out_im  out  W each  result real/imag
- out_id  out  1  index of the requester that issued the result

Behaviour:
- Reset (rst=1 at clk edge), required values:
  - state=IDLE
  - out_valid=0, out_re=0, out_im=0, out_id=0
  - rr_last=1, so requester 0 wins the first tie
  - Internal accumulators cleared.
- Reset mid-operation aborts the operation and discards its result.
- Arbitration, in IDLE only:
  - If exactly one valid, grant it.
  - If both valid, grant the requester ≠ rr_last.
  - reqK_ready = (state==IDLE) && grantK. Combinational; no ready outside IDLE.
  - On accept: latch operands, op and id; rr_last←id.
- States: IDLE, M1, M2, M3, FIN, DONE.
- add/sub:
  - Accept cycle T computes a±c and b±d into out_re/out_im.
  - Next state DONE; out_valid=1 from T+1.
- mul, accept at T:
  - T+1 (M1): mult operands (c, a+b); P←product.
  - T+2 (M2): acc_re←P, acc_im←P; operands (a, d−c).
  - T+3 (M3): acc_im←acc_im+P; operands (b, c+d).
  - T+4 (FIN): out_re←acc_re−P, out_im←acc_im.
  - T+5: DONE, out_valid=1.
- DONE:
  - Hold out_* stable while out_valid && !out_ready.
  - On out_ready: out_valid←0, state←IDLE. A new accept is possible the cycle after the handshake, so there is no same-cycle back-to-back.
- Throughput with out_ready held high:
  - mul: one result per 6 cycles.
  - add/sub: one result per 2 cycles.
- Simultaneous requests alternate strictly. A requester whose valid drops before grant loses nothing; there is no stored priority.
- op=11 without the macro: executes as op=01.

Optional Feature:
- Macro: CPLX_SEQ_CONJ_EN.
- Defined: op=11 multiplies by the conjugate, using d'=−d (mod 2^W) at latch time, then the same 3-product sequence and latency as mul.
- Undefined: op=11 is identical to mul; no negation logic is synthesised.

Decomposition:
- Package cplx_pkg holds:
  - op-code constants OP_ADD, OP_MUL, OP_SUB, OP_CMUL
  - state encoding localparams
  - default W
- Sub-module cplx_mul_unit: W×W multiplier with registered low-W-bit output P, enable input, 1-cycle latency.
- The scheduler owns only arbitration, the FSM, pre-adders and accumulators.

Test Plan:
- Mul: req0 mul (3+4i)(8+9i), out_ready=1 → out_valid exactly 5 cycles after accept; out_re=16'hFFF4 (−12), out_im=59, out_id=0.
- Add and sub: req1 add (3+4i)+(8+9i) → out_valid 1 cycle after accept, 11/13, out_id=1. Then sub (3+4i)−(8+9i) → 16'hFFFB/16'hFFFB.
- Arbitration: both valid continuously, mul (2+4i)(−6−3i) on both → grants alternate 0,1,0; every result re=0, im=16'hFFE2.
- Backpressure: out_ready=0 for 10 cycles after out_valid → outputs stable, both ready low. Release → result consumed; next accept occurs the following cycle.
- Reset mid-op: rst asserted during M2 → next cycle out_valid=0, IDLE, req0 wins the next tie.
- Conj-mul: op=11, (3+4i)(8+9i):
  - with CPLX_SEQ_CONJ_EN → 60/5
  - without → 16'hFFF4/59
